register_bank: RTL

- Parametrised, clocked successor to the single 8-bit bus register used in the 6502 datapath.
- Holds DEPTH registers of WIDTH bits, standing in for the CPU's A/X/Y/SP-style registers.
- One write port performs load, increment or decrement. Two read ports drive the internal bus and the ALU B input.
- Registered zero/negative/wrap flags are produced on every write, and the bus output enable is registered.

---
 rtl/register_bank.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/register_bank.sv
// ----------------------------------------------------------------------------
// register_bank
//
// Parametrised bank of DEPTH registers of WIDTH bits. It stands in for the
// A/X/Y/SP-style registers of a 6502-like datapath. One write port performs
// load, increment or decrement. Two combinational read ports drive the
// internal bus (A) and the ALU B input (B). Zero, negative and wrap flags are
// registered on every real write. The bus output enable is a one-cycle
// delayed copy of its request.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active high
//   wr_en       in   perform the write-port operation this cycle
//   wr_sel      in   target register index (>= DEPTH ignores the write)
//   wr_op       in   00 load, 01 increment, 10 decrement, 11 no-op
//   wr_data     in   load value, used only for wr_op = 00
//   rd_a_sel    in   read port A index (bus port)
//   rd_a_data   out  contents of register rd_a_sel, zero when out of range
//   rd_b_sel    in   read port B index (ALU port)
//   rd_b_data   out  contents of register rd_b_sel, zero when out of range
//   bus_oe_req  in   request to drive the internal bus from port A
//   bus_oe      out  registered enable for the external tristate driver
//   flag_z      out  last written result was zero
//   flag_n      out  MSB of last written result
//   flag_wrap   out  one-cycle pulse after an inc/dec that wrapped
// ----------------------------------------------------------------------------
module register_bank #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SP_INDEX    = 3,
  localparam int              SEL_W       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [1:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SEL_W-1:0] rd_a_sel,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [SEL_W-1:0] rd_b_sel,
  output logic [WIDTH-1:0] rd_b_data,
  input  logic             bus_oe_req,
  output logic             bus_oe,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_wrap
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_NOP  = 2'b11
  } wr_op_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic flag_z_q,    flag_z_d;
  logic flag_n_q,    flag_n_d;
  logic flag_wrap_q, flag_wrap_d;
  logic bus_oe_q;

  wr_op_e           op;
  logic             sel_hit;
  logic             do_write;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] result;
  logic             wrap_hit;

  assign op = wr_op_e'(wr_op);

  // Index decode is done by comparing against every legal index, so an
  // out-of-range select simply matches nothing and needs no range compare.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [SEL_W-1:0] sel,
    input logic [WIDTH-1:0] regs [DEPTH]
  );
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i)) val = regs[i];
    end
    return val;
  endfunction

  // Reads see the registered array only; a same-cycle write becomes visible
  // after the edge.
  assign rd_a_data = read_port(rd_a_sel, regs_q);
  assign rd_b_data = read_port(rd_b_sel, regs_q);

  always_comb begin : write_path
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    regs_d      = regs_q;
    sel_hit     = 1'b0;
    old_val     = '0;
    result      = '0;
    wrap_hit    = 1'b0;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel == SEL_W'(i)) begin
        sel_hit = 1'b1;
        old_val = regs_q[i];
      end
    end

    case (op)
      OP_LOAD: result = wr_data;
      OP_INC: begin
        result   = old_val + WIDTH'(1);
        wrap_hit = (old_val == '1);
      end
      OP_DEC: begin
        result   = old_val - WIDTH'(1);
        wrap_hit = (old_val == '0);
      end
      default: result = old_val;
    endcase

    do_write = wr_en && sel_hit && (op != OP_NOP);

    // The wrap pulse clears on every edge that is not a wrapping inc/dec;
    // z/n only move when a register really changes.
    flag_wrap_d = do_write && wrap_hit;
    if (do_write) begin
      flag_z_d = (result == '0);
      flag_n_d = result[WIDTH-1];
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel == SEL_W'(i)) regs_d[i] = result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this is a flop array, not a RAM macro, so every entry is reset.
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? {WIDTH{1'b1}} : RESET_VALUE;
      end
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_wrap_q <= 1'b0;
      bus_oe_q    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only.
      regs_q      <= regs_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_wrap_q <= flag_wrap_d;
      bus_oe_q    <= bus_oe_req;
    end
  end

  assign bus_oe    = bus_oe_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_wrap = flag_wrap_q;

endmodule
